// File: rtl/sram_axi_bridge_pkg.sv
// Shared types and constants for the SRAM-like to AXI3 bridge.
// Holds FSM encodings, SRAM size codes, AXI size codes and default IDs.
package sram_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4
    } state_e;

    // SRAM-side transfer size codes.
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // AXI AxSIZE encodings.
    localparam logic [2:0] AXI_SIZE_1B = 3'd0;
    localparam logic [2:0] AXI_SIZE_2B = 3'd1;
    localparam logic [2:0] AXI_SIZE_4B = 3'd2;

    localparam logic [3:0] INST_ID_DEFAULT = 4'd0;
    localparam logic [3:0] DATA_ID_DEFAULT = 4'd1;

    // The undefined code 3 passes through unchanged so the slave sees it as-is.
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        logic [2:0] result;
        unique case (size)
            SIZE_BYTE: result = AXI_SIZE_1B;
            SIZE_HALF: result = AXI_SIZE_2B;
            SIZE_WORD: result = AXI_SIZE_4B;
            default:   result = {1'b0, size};
        endcase
        return result;
    endfunction

endpackage

// File: rtl/sram_axi_bridge_wstrb_gen.sv
// Byte-lane strobe generator: transfer size plus address offset to a 4-bit wstrb.
// Kept standalone so a cache write path can share the same lane rules.
module sram_axi_bridge_wstrb_gen
    import sram_axi_bridge_pkg::*;
(
    input  logic [1:0] i_size,
    input  logic [1:0] i_offset,
    output logic [3:0] o_wstrb
);

    always_comb begin
        o_wstrb = 4'b0000;
        unique case (i_size)
            SIZE_BYTE: o_wstrb = 4'b0001 << i_offset;
            SIZE_HALF: o_wstrb = i_offset[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: o_wstrb = 4'b1111;
            // Size 3 is not a legal SRAM size: no lanes written, but the
            // write still runs to completion so the requester is not stuck.
            default:   o_wstrb = 4'b0000;
        endcase
    end

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the CPU's instruction and data SRAM-like ports onto one AXI3 master,
// one transaction at a time, data port having priority over instruction fetch.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter logic [3:0] INST_ID = INST_ID_DEFAULT,
    parameter logic [3:0] DATA_ID = DATA_ID_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    state_e      r_state;
    state_e      w_state_next;

    logic        r_owner_data;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic [31:0] r_wdata;
    logic        r_aw_done;
    logic        r_w_done;
    logic        r_inst_data_ok;
    logic        r_data_data_ok;
    logic [31:0] r_inst_rdata;
    logic [31:0] r_data_rdata;

    logic        w_grant_data;
    logic        w_grant_inst;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_ar_hs;
    logic        w_r_hs;
    logic        w_b_hs;
    logic [3:0]  w_wstrb;
    logic [3:0]  w_id;

    // Response IDs/status are not needed with a single outstanding transaction.
    logic        w_unused_axi;
    assign w_unused_axi = ^{rid, rresp, rlast, bid, bresp};

    // Gating with resetn keeps addr_ok low while the bridge is held in reset.
    assign w_grant_data = (r_state == ST_IDLE) && resetn && data_req;
    assign w_grant_inst = (r_state == ST_IDLE) && resetn && !data_req && inst_req;

    assign data_addr_ok = w_grant_data;
    assign inst_addr_ok = w_grant_inst;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        w_ar_hs      = 1'b0;
        w_r_hs       = 1'b0;
        w_aw_hs      = 1'b0;
        w_w_hs       = 1'b0;
        w_b_hs       = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_grant_data) begin
                    w_state_next = data_wr ? ST_WR_REQ : ST_RD_ADDR;
                end else if (w_grant_inst) begin
                    w_state_next = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                arvalid = 1'b1;
                w_ar_hs = arready;
                if (w_ar_hs) begin
                    w_state_next = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                rready = 1'b1;
                w_r_hs = rvalid;
                if (w_r_hs) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                // AW and W channels retire independently, in either order.
                awvalid = !r_aw_done;
                wvalid  = !r_w_done;
                w_aw_hs = awvalid && awready;
                w_w_hs  = wvalid && wready;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_next = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                bready = 1'b1;
                w_b_hs = bvalid;
                if (w_b_hs) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_owner_data   <= 1'b0;
            r_addr         <= 32'd0;
            r_size         <= 2'd0;
            r_wdata        <= 32'd0;
            r_aw_done      <= 1'b0;
            r_w_done       <= 1'b0;
            r_inst_data_ok <= 1'b0;
            r_data_data_ok <= 1'b0;
            r_inst_rdata   <= 32'd0;
            r_data_rdata   <= 32'd0;
        end else begin
            r_inst_data_ok <= 1'b0;
            r_data_data_ok <= 1'b0;

            if (w_grant_data) begin
                r_owner_data <= 1'b1;
                r_addr       <= data_addr;
                r_size       <= data_size;
                r_wdata      <= data_wdata;
                r_aw_done    <= 1'b0;
                r_w_done     <= 1'b0;
            end else if (w_grant_inst) begin
                r_owner_data <= 1'b0;
                r_addr       <= inst_addr;
                r_size       <= inst_size;
            end

            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end

            if (w_r_hs) begin
                if (r_owner_data) begin
                    r_data_rdata   <= rdata;
                    r_data_data_ok <= 1'b1;
                end else begin
                    r_inst_rdata   <= rdata;
                    r_inst_data_ok <= 1'b1;
                end
            end

            if (w_b_hs) begin
                r_data_data_ok <= 1'b1;
            end
        end
    end

    sram_axi_bridge_wstrb_gen u_wstrb_gen (
        .i_size   (r_size),
        .i_offset (r_addr[1:0]),
        .o_wstrb  (w_wstrb)
    );

    // Writes only ever come from the data port, so one ID mux serves all channels.
    assign w_id   = r_owner_data ? DATA_ID : INST_ID;

    assign arid   = w_id;
    assign araddr = r_addr;
    assign arsize = axi_size(r_size);

    assign awid   = w_id;
    assign awaddr = r_addr;
    assign awsize = axi_size(r_size);

    assign wid    = w_id;
    assign wdata  = r_wdata;
    assign wstrb  = w_wstrb;
    assign wlast  = 1'b1;

    assign inst_data_ok = r_inst_data_ok;
    assign inst_rdata   = r_inst_rdata;
    assign data_data_ok = r_data_data_ok;
    assign data_rdata   = r_data_rdata;

endmodule
